// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: RISC-V instruction-fetch front end.
// Issues in-order word fetches under a credit limit, buffers {pc, instr} pairs and flushes on redirect.
module if_prefetch_unit #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_instr,
    input  logic            id_ready
);

    localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned     CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP    = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] fifo_pc    [DEPTH];
    logic [XLEN-1:0] fifo_instr [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;

    logic [CW:0]     credit_used;
    logic            req_fire;
    logic            rsp_keep;
    logic            pop;

    // A request is only issued if a FIFO slot is already reserved for its response,
    // so responses never need backpressure.
    assign credit_used    = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = rst & ~redirect_valid & (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;

    assign rsp_keep = imem_rsp_valid & (discard == '0) & ~redirect_valid;
    assign if_valid = (count != '0);
    assign pop      = if_valid & id_ready & ~redirect_valid;
    assign if_pc    = fifo_pc[rd_ptr];
    assign if_instr = fifo_instr[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= RESET_PC;
            rsp_pc      <= RESET_PC;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            // NOTE: the FIFO array is reset too so the head outputs read zero out of reset.
            for (int i = 0; i < int'(DEPTH); i++) begin
                fifo_pc[i]    <= '0;
                fifo_instr[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments keep every update here based on pre-edge values.
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
            if (redirect_valid) begin
                pc_q    <= redirect_pc;
                rsp_pc  <= redirect_pc;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count   <= '0;
                discard <= outstanding - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + STEP;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - CW'(1);
                end
                if (rsp_keep) begin
                    fifo_pc[wr_ptr]    <= rsp_pc;
                    fifo_instr[wr_ptr] <= imem_rsp_data;
                    wr_ptr             <= wr_ptr + PW'(1);
                    rsp_pc             <= rsp_pc + STEP;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(rsp_keep) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Testbench for if_prefetch_unit: behavioural instruction memory plus an in-order
// scoreboard of expected {pc, instr} pairs filled as requests are accepted.
module tb_if_prefetch_unit;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        id_ready;

    if_prefetch_unit #(.XLEN(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .id_ready       (id_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } mem_entry_t;

    mem_entry_t  mem_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pop_log[$];
    logic [31:0] model_pc;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          n_fire = 0;
    int          n_pop = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          ready_mode = 0;
    bit          last_fire, last_pop, last_rsp, last_ifv;

    // One clock cycle: drive inputs at the falling edge, sample just after, update models,
    // then advance to the next falling edge.
    task automatic step(input logic redir, input logic [31:0] rpc);
        mem_entry_t  m;
        logic [31:0] e;
        int          stale_n;
        int          lat;
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        imem_req_ready = ready_mode ? ((cyc % 2) == 0) : 1'b1;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_q[0].addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
        #1;
        last_fire = imem_req_valid && imem_req_ready;
        last_pop  = if_valid && id_ready && !redir;
        last_rsp  = imem_rsp_valid;
        last_ifv  = if_valid;
        if (last_rsp) void'(mem_q.pop_front());
        if (redir) begin
            total++;
            if (imem_req_valid !== 1'b0) begin
                bad++;
                $display("FAIL req_in_redirect got=%b want=0", imem_req_valid);
            end
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
            exp_q.delete();
            model_pc = rpc;
        end else begin
            if (last_pop) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected_pop got pc=%h instr=%h", if_pc, if_instr);
                end else begin
                    e = exp_q.pop_front();
                    if (if_pc !== e || if_instr !== (e ^ KEY)) begin
                        bad++;
                        $display("FAIL sb_pop got pc=%h instr=%h want pc=%h instr=%h",
                                 if_pc, if_instr, e, e ^ KEY);
                    end
                end
                pop_log.push_back(if_pc);
                n_pop++;
            end
            if (last_fire) begin
                total++;
                if (imem_req_addr !== model_pc) begin
                    bad++;
                    $display("FAIL req_addr got=%h want=%h", imem_req_addr, model_pc);
                end
                lat   = $urandom_range(lat_max, lat_min);
                m.addr  = imem_req_addr;
                m.due   = cyc + lat;
                if (mem_q.size() > 0 && mem_q[$].due >= m.due) m.due = mem_q[$].due + 1;
                m.stale = 1'b0;
                mem_q.push_back(m);
                exp_q.push_back(model_pc);
                model_pc = model_pc + 32'd4;
                n_fire++;
            end
        end
        stale_n = 0;
        foreach (mem_q[i]) if (mem_q[i].stale) stale_n++;
        total++;
        if (exp_q.size() + stale_n > DEPTH) begin
            bad++;
            $display("FAIL credit got=%0d want<=%0d", exp_q.size() + stale_n, DEPTH);
        end
        @(posedge clk);
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic run_until_pops(input int target, input int budget, input string tag);
        int n = 0;
        while (n_pop < target && n < budget) begin
            step(1'b0, 32'h0);
            n++;
        end
        if (n_pop < target) begin
            total++;
            bad++;
            $display("FAIL %s_timeout got pops=%0d want=%0d", tag, n_pop, target);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        ready_mode     = 1'b0;
        lat_min        = 1;
        lat_max        = 1;
        @(negedge clk);
        @(negedge clk);
        mem_q.delete();
        exp_q.delete();
        pop_log.delete();
        model_pc = RESET_PC;
        n_fire   = 0;
        n_pop    = 0;
        rst      = 1'b1;
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic test_reset();
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_eq("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        expect_eq("rst_req_addr", imem_req_addr, RESET_PC);
        expect_eq("rst_if_valid", {31'h0, if_valid}, 32'h0);
        expect_eq("rst_if_pc", if_pc, 32'h0);
        expect_eq("rst_if_instr", if_instr, 32'h0);
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            step(1'b0, 32'h0);
            if (i == 1) expect_eq("stream_first_req", {31'h0, last_fire}, 32'h1);
            if (i == 2) expect_eq("stream_no_pop_c2", {31'h0, last_ifv}, 32'h0);
        end
        expect_eq("stream_pops", n_pop, 18);
    endtask

    task automatic test_backpressure();
        do_reset();
        id_ready = 1'b0;
        repeat (10) step(1'b0, 32'h0);
        expect_eq("bp_fires", n_fire, 4);
        #1;
        expect_eq("bp_req_low", {31'h0, imem_req_valid}, 32'h0);
        id_ready = 1'b1;
        run_until_pops(4, 30, "bp");
        for (int i = 0; i < 4; i++) expect_eq("bp_order", pop_log[i], 32'(4 * i));
    endtask

    task automatic test_redirect_inflight();
        int n = 0;
        do_reset();
        lat_min = 3;
        lat_max = 3;
        while (mem_q.size() < 3 && n < 20) begin
            step(1'b0, 32'h0);
            n++;
        end
        expect_eq("rdi_outstanding", mem_q.size(), 3);
        step(1'b1, 32'h100);
        #1;
        expect_eq("rdi_if_valid_r1", {31'h0, if_valid}, 32'h0);
        expect_eq("rdi_req_valid_r1", {31'h0, imem_req_valid}, 32'h1);
        expect_eq("rdi_req_addr_r1", imem_req_addr, 32'h100);
        pop_log.delete();
        run_until_pops(n_pop + 2, 40, "rdi");
        expect_eq("rdi_first_pc", pop_log[0], 32'h100);
        expect_eq("rdi_second_pc", pop_log[1], 32'h104);
    endtask

    task automatic test_redirect_coincident();
        do_reset();
        repeat (6) step(1'b0, 32'h0);
        step(1'b1, 32'h200);
        expect_eq("coinc_pre", {30'h0, last_ifv, last_rsp}, 32'h3);
        #1;
        expect_eq("coinc_count0", {31'h0, if_valid}, 32'h0);
        expect_eq("coinc_req_addr", imem_req_addr, 32'h200);
        pop_log.delete();
        run_until_pops(n_pop + 1, 20, "coinc");
        expect_eq("coinc_resume_pc", pop_log[0], 32'h200);
    endtask

    task automatic test_slow_memory();
        do_reset();
        ready_mode = 1'b1;
        lat_min    = 1;
        lat_max    = 4;
        for (int i = 0; i < 300; i++) begin
            id_ready = 1'($urandom_range(1, 0));
            step(1'b0, 32'h0);
        end
        total++;
        if (n_pop < 20) begin
            bad++;
            $display("FAIL slow_progress got=%0d want>=20", n_pop);
        end
        ready_mode = 1'b0;
        id_ready   = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (3) step(1'b0, 32'h0);
        step(1'b1, 32'hFFFF_FFF8);
        pop_log.delete();
        run_until_pops(n_pop + 3, 20, "wrap");
        expect_eq("wrap_pc0", pop_log[0], 32'hFFFF_FFF8);
        expect_eq("wrap_pc1", pop_log[1], 32'hFFFF_FFFC);
        expect_eq("wrap_pc2", pop_log[2], 32'h0000_0000);
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (8) step(1'b0, 32'h0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        expect_eq("arst_if_valid", {31'h0, if_valid}, 32'h0);
        expect_eq("arst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        expect_eq("arst_if_pc", if_pc, 32'h0);
        mem_q.delete();
        exp_q.delete();
        pop_log.delete();
        model_pc = RESET_PC;
        @(negedge clk);
        rst = 1'b1;
        run_until_pops(n_pop + 2, 20, "arst");
        expect_eq("arst_restart_pc", pop_log[0], RESET_PC);
        expect_eq("arst_next_pc", pop_log[1], RESET_PC + 32'd4);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_coincident();
        test_slow_memory();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
